// File: rtl/or16_chk_pkg.sv
// Shared types and default sizes for the 16-bit OR response checker.
package or16_chk_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } chk_state_e;

endpackage

// File: rtl/or16_response_checker_sat_counter.sv
// Saturating up-counter with a registered at-max flag that tracks the count.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_max_q, at_max_d;

    always_comb begin
        count_d  = count_q;
        if (inc && !at_max_q) begin
            count_d = count_q + CNT_W'(1);
        end
        at_max_d = (count_d == MAX_VAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            at_max_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_max_q <= at_max_d;
        end
    end

    assign count  = count_q;
    assign at_max = at_max_q;

endmodule

// File: rtl/or16_response_checker.sv
// Response monitor for the 16-bit OR datapath: one-stage golden compare,
// saturating vector/error counts, first-fail capture and a drained verdict.
module or16_response_checker
    import or16_chk_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_out,
    input  logic             end_of_test,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             sat,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [WIDTH-1:0] first_fail_out,
    output logic             done,
    output logic             pass
);

    chk_state_e       state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0] s1_out_q, s1_out_d;
    logic             ff_valid_q, ff_valid_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d;
    logic [WIDTH-1:0] ff_b_q, ff_b_d;
    logic [WIDTH-1:0] ff_out_q, ff_out_d;

    logic             accept;
    logic             mismatch;
    logic             vec_at_max;
    logic             err_at_max;

    // Ready is masked by reset so nothing is taken while results are being cleared.
    assign in_ready = (state_q == RUN) && !reset;
    assign accept   = in_valid && in_ready;
    assign mismatch = s1_valid_q && (s1_out_q != (s1_a_q | s1_b_q));

    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_out_d   = s1_out_q;
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_a_d     = ff_a_q;
        ff_b_d     = ff_b_q;
        ff_out_d   = ff_out_q;

        if (accept) begin
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_out_d = in_out;
        end

        // Capture index is the count before this vector is added.
        if (mismatch && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = vec_count;
            ff_a_d     = s1_a_q;
            ff_b_d     = s1_b_q;
            ff_out_d   = s1_out_q;
        end

        case (state_q)
            RUN:     if (end_of_test) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_out_q   <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_out_q   <= s1_out_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_a_q     <= ff_a_d;
            ff_b_q     <= ff_b_d;
            ff_out_q   <= ff_out_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (s1_valid_q),
        .count  (vec_count),
        .at_max (vec_at_max)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (mismatch),
        .count  (err_count),
        .at_max (err_at_max)
    );

    // Both at-max flags are sticky until reset, so their OR is too.
    assign sat              = vec_at_max || err_at_max;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_a     = ff_a_q;
    assign first_fail_b     = ff_b_q;
    assign first_fail_out   = ff_out_q;
    assign done             = (state_q == DONE);
    assign pass             = done && (err_count == '0) && (vec_count != '0);

endmodule

// File: tb/tb_or16_response_checker.sv
// Scenario bench for or16_response_checker with a vector scoreboard monitor.
module tb_or16_response_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b, in_out;
    logic        end_of_test;
    logic [7:0]  vec_count, err_count, first_fail_idx;
    logic        sat, first_fail_valid, done, pass;
    logic [15:0] first_fail_a, first_fail_b, first_fail_out;

    logic        in_ready2;
    logic [1:0]  vec_count2, err_count2, first_fail_idx2;
    logic        sat2, first_fail_valid2, done2, pass2;
    logic [15:0] first_fail_a2, first_fail_b2, first_fail_out2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        mis;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         e;
    logic [7:0]  prev_vec;
    logic [7:0]  m_err;
    logic        m_ffv;
    logic [7:0]  m_idx;
    logic [15:0] m_a, m_b, m_o;

    always #5 clk = ~clk;

    or16_response_checker #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_out(in_out), .end_of_test(end_of_test),
        .vec_count(vec_count), .err_count(err_count), .sat(sat),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b),
        .first_fail_out(first_fail_out), .done(done), .pass(pass)
    );

    or16_response_checker #(.WIDTH(16), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_out(in_out), .end_of_test(end_of_test),
        .vec_count(vec_count2), .err_count(err_count2), .sat(sat2),
        .first_fail_valid(first_fail_valid2), .first_fail_idx(first_fail_idx2),
        .first_fail_a(first_fail_a2), .first_fail_b(first_fail_b2),
        .first_fail_out(first_fail_out2), .done(done2), .pass(pass2)
    );

    // Scoreboard: each vector-count step of the 8-bit instance pops one expected vector.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            prev_vec = 8'd0;
            m_err    = 8'd0;
            m_ffv    = 1'b0;
            m_idx    = 8'd0;
            m_a      = 16'd0;
            m_b      = 16'd0;
            m_o      = 16'd0;
        end else if (vec_count !== prev_vec) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: vec_count=%0d prev=%0d with no vector pending", vec_count, prev_vec);
            end else begin
                e = sb_q.pop_front();
                if (e.mis) begin
                    m_err = m_err + 8'd1;
                    if (!m_ffv) begin
                        m_ffv = 1'b1;
                        m_idx = prev_vec;
                        m_a   = e.a;
                        m_b   = e.b;
                        m_o   = e.o;
                    end
                end
                if (vec_count !== prev_vec + 8'd1) begin
                    errors++;
                    $display("FAIL sb_vec_step: got %0d want %0d", vec_count, prev_vec + 8'd1);
                end
                checks++;
                if (err_count !== m_err) begin
                    errors++;
                    $display("FAIL sb_err_count: got %0d want %0d", err_count, m_err);
                end
                checks++;
                if (first_fail_valid !== m_ffv || (m_ffv && (first_fail_idx !== m_idx ||
                    first_fail_a !== m_a || first_fail_b !== m_b || first_fail_out !== m_o))) begin
                    errors++;
                    $display("FAIL sb_first_fail: got v=%b idx=%0d %h/%h/%h want v=%b idx=%0d %h/%h/%h",
                             first_fail_valid, first_fail_idx, first_fail_a, first_fail_b, first_fail_out,
                             m_ffv, m_idx, m_a, m_b, m_o);
                end
            end
            prev_vec = vec_count;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
        sb_t ent;
        ent.mis = (o !== (a | b));
        ent.a = a;
        ent.b = b;
        ent.o = o;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_out = o;
        sb_q.push_back(ent);
        @(posedge clk); #1;
    endtask

    task automatic eot_and_drain();
        in_valid = 1'b0;
        end_of_test = 1'b1;
        @(posedge clk); #1;
        end_of_test = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        end_of_test = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; end_of_test = 1'b0;
        in_a = 16'h0; in_b = 16'h0; in_out = 16'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low: got %b want 0", in_ready);
        end
        checks++;
        if ({vec_count, err_count, sat, first_fail_valid, done, pass} !== 20'h0) begin
            errors++; $display("FAIL reset_outputs: vec=%0d err=%0d sat=%b ffv=%b done=%b pass=%b want all 0",
                               vec_count, err_count, sat, first_fail_valid, done, pass);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_high: got %b want 1", in_ready);
        end
    endtask

    task automatic test_all_correct();
        apply_reset();
        send(16'hAAAA, 16'h5555, 16'hFFFF);
        send(16'h0000, 16'h0000, 16'h0000);
        send(16'h1234, 16'h0F0F, 16'h1F3F);
        send(16'h8000, 16'h0001, 16'h8001);
        send(16'hFFFF, 16'h0000, 16'hFFFF);
        send(16'h00F0, 16'h0F00, 16'h0FF0);
        in_valid = 1'b0;
        end_of_test = 1'b1;
        @(posedge clk); #1;
        end_of_test = 1'b0;
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL correct_drain: done=%b ready=%b want 0/0", done, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 8'd6 || err_count !== 8'd0) begin
            errors++; $display("FAIL correct_verdict: done=%b pass=%b vec=%0d err=%0d want 1/1/6/0",
                               done, pass, vec_count, err_count);
        end
    endtask

    task automatic test_single_fault();
        apply_reset();
        send(16'h0001, 16'h0002, 16'h0003);
        send(16'hF000, 16'h000F, 16'hF00F);
        send(16'h5A5A, 16'hA5A5, 16'hFFFF);
        send(16'h3CC3, 16'h0FF0, 16'h3FF2);
        send(16'h4000, 16'h0004, 16'h4004);
        eot_and_drain();
        checks++;
        if (err_count !== 8'd1 || vec_count !== 8'd5 || pass !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL single_counts: err=%0d vec=%0d pass=%b done=%b want 1/5/0/1",
                               err_count, vec_count, pass, done);
        end
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_idx !== 8'd3 || first_fail_a !== 16'h3CC3 ||
            first_fail_b !== 16'h0FF0 || first_fail_out !== 16'h3FF2) begin
            errors++; $display("FAIL single_capture: v=%b idx=%0d %h/%h/%h want 1 3 3cc3/0ff0/3ff2",
                               first_fail_valid, first_fail_idx, first_fail_a, first_fail_b, first_fail_out);
        end
    endtask

    task automatic test_two_faults();
        apply_reset();
        send(16'h1111, 16'h2222, 16'h3333);
        send(16'h00FF, 16'hFF00, 16'hFFFE);
        send(16'h0F0F, 16'h0F0F, 16'h0F0F);
        send(16'hC000, 16'h0003, 16'hC003);
        send(16'h0101, 16'h1010, 16'h0000);
        send(16'h7777, 16'h8888, 16'hFFFF);
        eot_and_drain();
        checks++;
        if (err_count !== 8'd2 || vec_count !== 8'd6 || pass !== 1'b0) begin
            errors++; $display("FAIL two_counts: err=%0d vec=%0d pass=%b want 2/6/0", err_count, vec_count, pass);
        end
        checks++;
        if (first_fail_idx !== 8'd1 || first_fail_a !== 16'h00FF || first_fail_b !== 16'hFF00 ||
            first_fail_out !== 16'hFFFE) begin
            errors++; $display("FAIL two_capture: idx=%0d %h/%h/%h want 1 00ff/ff00/fffe",
                               first_fail_idx, first_fail_a, first_fail_b, first_fail_out);
        end
    endtask

    task automatic test_eot_same_cycle();
        sb_t ent;
        apply_reset();
        ent.mis = 1'b0; ent.a = 16'h1234; ent.b = 16'h9876; ent.o = 16'h9A76;
        sb_q.push_back(ent);
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h9876; in_out = 16'h9A76;
        end_of_test = 1'b1;
        @(posedge clk); #1;
        end_of_test = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL eot_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 8'd1) begin
            errors++; $display("FAIL eot_verdict: done=%b pass=%b vec=%0d want 1/1/1", done, pass, vec_count);
        end
        in_a = 16'h0000; in_b = 16'h0000; in_out = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            end_of_test = i[0];
            @(posedge clk); #1;
        end
        end_of_test = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (vec_count !== 8'd1 || err_count !== 8'd0 || done !== 1'b1 || pass !== 1'b1) begin
            errors++; $display("FAIL done_hold: vec=%0d err=%0d done=%b pass=%b want 1/0/1/1",
                               vec_count, err_count, done, pass);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send(16'(i * 3), 16'h0100, 16'(i * 3) | 16'h0100);
        end
        eot_and_drain();
        checks++;
        if (vec_count2 !== 2'd3 || sat2 !== 1'b1 || pass2 !== 1'b1 || done2 !== 1'b1) begin
            errors++; $display("FAIL sat_small: vec=%0d sat=%b pass=%b done=%b want 3/1/1/1",
                               vec_count2, sat2, pass2, done2);
        end
        checks++;
        if (vec_count !== 8'd5 || sat !== 1'b0 || pass !== 1'b1) begin
            errors++; $display("FAIL sat_wide: vec=%0d sat=%b pass=%b want 5/0/1", vec_count, sat, pass);
        end
        apply_reset();
        eot_and_drain();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || done2 !== 1'b1 || pass2 !== 1'b0) begin
            errors++; $display("FAIL empty_verdict: done=%b pass=%b done2=%b pass2=%b want 1/0/1/0",
                               done, pass, done2, pass2);
        end
    endtask

    task automatic test_reset_in_drain();
        apply_reset();
        send(16'h0F00, 16'h00F0, 16'h0000);
        in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_out = 16'h0001;
        end_of_test = 1'b1;
        @(posedge clk); #1;
        end_of_test = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({vec_count, err_count, first_fail_idx, sat, first_fail_valid, done, pass, in_ready} !== 29'h0 ||
            {first_fail_a, first_fail_b, first_fail_out} !== 48'h0) begin
            errors++; $display("FAIL drain_reset_clear: vec=%0d err=%0d ffv=%b idx=%0d done=%b pass=%b ready=%b want all 0",
                               vec_count, err_count, first_fail_valid, first_fail_idx, done, pass, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || vec_count !== 8'd0 || err_count !== 8'd0) begin
            errors++; $display("FAIL drain_reset_run: ready=%b done=%b vec=%0d err=%0d want 1/0/0/0",
                               in_ready, done, vec_count, err_count);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_correct();
        test_single_fault();
        test_two_faults();
        test_eot_same_cycle();
        test_saturation();
        test_reset_in_drain();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d pending vectors want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
